// File: rtl/bool_lut_pkg.sv
// Shared types and constants for the programmable truth-table evaluator.
package bool_lut_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } cfg_state_e;

  localparam int unsigned DEFAULT_N_IN  = 4;
  localparam logic [15:0] DEFAULT_TABLE = 16'h0675;

  function automatic int unsigned tbl_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/bool_lut_eval_if.sv
// Evaluation and serial-configuration signals of bool_lut_eval.
interface bool_lut_eval_if
  import bool_lut_pkg::*;
#(
  parameter int unsigned N_IN = DEFAULT_N_IN
);

  logic            in_valid;
  logic [N_IN-1:0] X;
  logic            S;
  logic            out_valid;
  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_abort;
  logic            cfg_busy;
  logic            cfg_done;

  modport master (
    output in_valid, X, cfg_start, cfg_valid, cfg_bit, cfg_abort,
    input  S, out_valid, cfg_busy, cfg_done
  );

  modport slave (
    input  in_valid, X, cfg_start, cfg_valid, cfg_bit, cfg_abort,
    output S, out_valid, cfg_busy, cfg_done
  );

endinterface

// File: rtl/bool_lut_eval_cfg_loader.sv
// Serial loader: shadow table, bit counter and RUN/LOAD control.
// commit_o marks the edge that samples the final bit; shadow_o then includes it.
module lut_cfg_loader
  import bool_lut_pkg::*;
#(
  parameter int unsigned N_IN = DEFAULT_N_IN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start_i,
  input  logic                       cfg_valid_i,
  input  logic                       cfg_bit_i,
  input  logic                       cfg_abort_i,
  output logic                       cfg_busy_o,
  output logic                       cfg_done_o,
  output logic                       commit_o,
  output logic [tbl_width(N_IN)-1:0] shadow_o
);

  localparam int unsigned     TW       = tbl_width(N_IN);
  localparam logic [N_IN-1:0] CNT_LAST = '1;

  cfg_state_e      state_q, state_d;
  logic [N_IN-1:0] cnt_q, cnt_d;
  logic [TW-1:0]   shadow_q, shadow_d;
  logic            done_q, done_d;
  logic            commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  // Abort outranks restart, restart outranks a data bit in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cfg_start_i) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      ST_LOAD: begin
        if (cfg_abort_i) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (cfg_start_i) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (cfg_valid_i) begin
          shadow_d[cnt_q] = cfg_bit_i;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            commit  = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    done_d = commit;
  end

  always_comb begin
    cfg_busy_o = (state_q == ST_LOAD);
    cfg_done_o = done_q;
    commit_o   = commit;
    shadow_o   = shadow_d;
  end

endmodule

// File: rtl/bool_lut_eval.sv
// Registered evaluator of an N_IN-input Boolean function held as a truth table,
// reloadable at run time through a serial port with atomic commit.
module bool_lut_eval
  import bool_lut_pkg::*;
#(
  parameter int unsigned                N_IN = DEFAULT_N_IN,
  parameter logic [tbl_width(N_IN)-1:0] INIT = DEFAULT_TABLE
) (
  input logic            clk,
  input logic            rst,
  bool_lut_eval_if.slave bus
);

  localparam int unsigned TW = tbl_width(N_IN);

  logic [TW-1:0] tbl_q, tbl_d;
  logic          s_q, s_d;
  logic          vld_q, vld_d;
  logic          commit;
  logic [TW-1:0] shadow;
  logic          busy;
  logic          done;

  lut_cfg_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk         (clk),
    .rst         (rst),
    .cfg_start_i (bus.cfg_start),
    .cfg_valid_i (bus.cfg_valid),
    .cfg_bit_i   (bus.cfg_bit),
    .cfg_abort_i (bus.cfg_abort),
    .cfg_busy_o  (busy),
    .cfg_done_o  (done),
    .commit_o    (commit),
    .shadow_o    (shadow)
  );

  // Lookup reads tbl_q, so a word sampled on the commit edge still sees the old table.
  always_comb begin
    tbl_d = commit ? shadow : tbl_q;
    s_d   = bus.in_valid ? tbl_q[bus.X] : s_q;
    vld_d = bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_q <= INIT;
      s_q   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      tbl_q <= tbl_d;
      s_q   <= s_d;
      vld_q <= vld_d;
    end
  end

  assign bus.S         = s_q;
  assign bus.out_valid = vld_q;
  assign bus.cfg_busy  = busy;
  assign bus.cfg_done  = done;

endmodule
